// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB for the RISC datapath,
// with a memory-ready handshake, a wait watchdog and sticky status flags.
module multicycle_ctrl #(
    parameter int OPW      = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic [1:0]     M2,
    output logic           reg_we,
    output logic           alu_src,
    output logic [1:0]     alu_op,
    output logic           pc_we,
    output logic [1:0]     pc_src,
    output logic           ir_we,
    output logic           mem_re,
    output logic           mem_we,
    output logic [2:0]     state,
    output logic           halted,
    output logic           illegal,
    output logic           mem_err
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(0);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_LW    = OPW'(2);
    localparam logic [OPW-1:0] OP_SW    = OPW'(3);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(4);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(5);
    localparam logic [OPW-1:0] OP_J     = OPW'(6);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(15);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q;
    logic [CW-1:0]  wait_q;
    logic           halted_q, illegal_q, mem_err_q;

    logic           set_illegal;
    logic           timeout;
    logic           mem_phase;

    logic [1:0]     m2_c, alu_op_c, pc_src_c;
    logic           reg_we_c, alu_src_c, pc_we_c, ir_we_c, mem_re_c, mem_we_c;

    // Handshake: mem_re/mem_we are held high for the whole access; the access
    // completes on the first cycle mem_ready is sampled high alongside the request.
    assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
    assign timeout   = mem_phase && !mem_ready && (wait_q == CW'(WAIT_MAX));

    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        m2_c        = 2'd0;
        reg_we_c    = 1'b0;
        alu_src_c   = 1'b0;
        alu_op_c    = 2'd0;
        pc_we_c     = 1'b0;
        pc_src_c    = 2'd0;
        ir_we_c     = 1'b0;
        mem_re_c    = 1'b0;
        mem_we_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_re_c = 1'b1;
                if (mem_ready) begin
                    ir_we_c = 1'b1;
                    pc_we_c = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE, OP_ADDI, OP_LW, OP_SW,
                    OP_BEQ, OP_JAL, OP_J:         state_d = S_EXEC;
                    OP_HALT:                      state_d = S_HALT;
                    default: begin
                        set_illegal = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                case (op_q)
                    OP_RTYPE: begin
                        alu_op_c = 2'd2;
                        state_d  = S_WB;
                    end
                    OP_ADDI: begin
                        alu_src_c = 1'b1;
                        state_d   = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_c = 1'b1;
                        state_d   = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op_c = 2'd1;
                        pc_we_c  = zero;
                        pc_src_c = 2'd1;
                        state_d  = S_FETCH;
                    end
                    OP_J: begin
                        pc_we_c  = 1'b1;
                        pc_src_c = 2'd2;
                        state_d  = S_FETCH;
                    end
                    OP_JAL: begin
                        // The datapath captures PC into the link path before this update.
                        pc_we_c  = 1'b1;
                        pc_src_c = 2'd2;
                        state_d  = S_WB;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                mem_re_c = (op_q == OP_LW);
                mem_we_c = (op_q == OP_SW);
                if (mem_ready) begin
                    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                end else if (timeout) begin
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                reg_we_c = 1'b1;
                case (op_q)
                    OP_RTYPE: m2_c = 2'd1;
                    OP_JAL:   m2_c = 2'd2;
                    default:  m2_c = 2'd0;
                endcase
                state_d = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= '0;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            // Saturating wait counter, restarted on any state change or ready.
            if ((state_d != state_q) || mem_ready) begin
                wait_q <= '0;
            end else if (mem_phase && (wait_q != CW'(WAIT_MAX))) begin
                wait_q <= wait_q + CW'(1);
            end
            if (state_d == S_HALT) begin
                halted_q <= 1'b1;
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (timeout) begin
                mem_err_q <= 1'b1;
            end
        end
    end

    // Reset suppresses every strobe combinationally so an abandoned access ends at once.
    assign M2      = rst ? 2'd0 : m2_c;
    assign reg_we  = rst ? 1'b0 : reg_we_c;
    assign alu_src = rst ? 1'b0 : alu_src_c;
    assign alu_op  = rst ? 2'd0 : alu_op_c;
    assign pc_we   = rst ? 1'b0 : pc_we_c;
    assign pc_src  = rst ? 2'd0 : pc_src_c;
    assign ir_we   = rst ? 1'b0 : ir_we_c;
    assign mem_re  = rst ? 1'b0 : mem_re_c;
    assign mem_we  = rst ? 1'b0 : mem_we_c;

    assign state   = state_q;
    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-by-cycle bench for multicycle_ctrl: per-instruction expected control words
// are queued as stimulus is driven and compared at the falling edge.
module tb_multicycle_ctrl;

    localparam int OPW      = 4;
    localparam int WAIT_MAX = 15;

    logic           clk = 1'b0;
    logic           rst;
    logic [OPW-1:0] opcode;
    logic           zero;
    logic           mem_ready;
    logic [1:0]     M2;
    logic           reg_we;
    logic           alu_src;
    logic [1:0]     alu_op;
    logic           pc_we;
    logic [1:0]     pc_src;
    logic           ir_we;
    logic           mem_re;
    logic           mem_we;
    logic [2:0]     state;
    logic           halted;
    logic           illegal;
    logic           mem_err;

    always #5 clk = ~clk;

    multicycle_ctrl #(.OPW(OPW), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .M2(M2), .reg_we(reg_we), .alu_src(alu_src), .alu_op(alu_op),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_re(mem_re),
        .mem_we(mem_we), .state(state), .halted(halted), .illegal(illegal),
        .mem_err(mem_err)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [17:0] exp_q[$];
    logic        halted_e, illegal_e, err_e;

    // word: state, M2, reg_we, alu_src, alu_op, pc_we, pc_src, ir_we, mem_re, mem_we, halted, illegal, mem_err
    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [17:0] observed();
        return {state, M2, reg_we, alu_src, alu_op, pc_we, pc_src, ir_we,
                mem_re, mem_we, halted, illegal, mem_err};
    endfunction

    task automatic ex(input string tag, input logic [2:0] st, input logic [1:0] m2,
                      input logic rw, input logic as, input logic [1:0] ao,
                      input logic pw, input logic [1:0] ps, input logic iw,
                      input logic mr, input logic mw);
        exp_q.push_back({st, m2, rw, as, ao, pw, ps, iw, mr, mw, halted_e, illegal_e, err_e});
        @(negedge clk);
        check(tag, observed(), exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input int waits);
        opcode = 4'($urandom_range(0, 15));
        for (int i = 0; i < waits; i++) begin
            mem_ready = 1'b0;
            ex("fetch_wait", 3'd0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 1, 0);
        end
        mem_ready = 1'b1;
        ex("fetch", 3'd0, 2'd0, 0, 0, 2'd0, 1, 2'd0, 1, 1, 0);
    endtask

    task automatic do_decode(input logic [3:0] op);
        opcode    = op;
        mem_ready = 1'($urandom_range(0, 1));
        ex("decode", 3'd1, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
        if (op == 4'd15) halted_e = 1'b1;
        else if (op > 4'd6) illegal_e = 1'b1;
    endtask

    task automatic do_exec(input logic [3:0] op, input logic z);
        opcode    = 4'($urandom_range(0, 15));
        zero      = z;
        mem_ready = 1'($urandom_range(0, 1));
        case (op)
            4'd0:             ex("exec_rtype", 3'd2, 2'd0, 0, 0, 2'd2, 0, 2'd0, 0, 0, 0);
            4'd1, 4'd2, 4'd3: ex("exec_imm",   3'd2, 2'd0, 0, 1, 2'd0, 0, 2'd0, 0, 0, 0);
            4'd4:             ex("exec_beq",   3'd2, 2'd0, 0, 0, 2'd1, z, 2'd1, 0, 0, 0);
            default:          ex("exec_jump",  3'd2, 2'd0, 0, 0, 2'd0, 1, 2'd2, 0, 0, 0);
        endcase
    endtask

    task automatic do_mem(input logic [3:0] op, input int waits);
        int n;
        n = (waits > WAIT_MAX) ? WAIT_MAX + 1 : waits;
        opcode = 4'($urandom_range(0, 15));
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'b0;
            ex("mem_wait", 3'd3, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, op == 4'd2, op == 4'd3);
        end
        if (waits > WAIT_MAX) begin
            err_e    = 1'b1;
            halted_e = 1'b1;
        end else begin
            mem_ready = 1'b1;
            ex("mem", 3'd3, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, op == 4'd2, op == 4'd3);
        end
    endtask

    task automatic do_wb(input logic [3:0] op);
        logic [1:0] m2;
        m2 = (op == 4'd0) ? 2'd1 : (op == 4'd5) ? 2'd2 : 2'd0;
        opcode    = 4'($urandom_range(0, 15));
        mem_ready = 1'($urandom_range(0, 1));
        ex("wb", 3'd4, m2, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0);
    endtask

    task automatic do_halt(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            opcode    = 4'($urandom_range(0, 15));
            ex("halt", 3'd5, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic z, input int fw, input int mw);
        do_fetch(fw);
        do_decode(op);
        if (op == 4'd15) begin
            do_halt(3);
        end else if (op <= 4'd6) begin
            do_exec(op, z);
            if (op == 4'd2 || op == 4'd3) do_mem(op, mw);
            if (err_e) do_halt(3);
            else if (op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd5) do_wb(op);
        end
    endtask

    // One cycle with rst high: register state still visible, every strobe low.
    task automatic reset_pulse(input logic [2:0] cur);
        rst       = 1'b1;
        mem_ready = 1'b1;
        opcode    = 4'($urandom_range(0, 15));
        ex("rst", cur, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
        rst       = 1'b0;
        halted_e  = 1'b0;
        illegal_e = 1'b0;
        err_e     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; opcode = '0;
        halted_e = 1'b0; illegal_e = 1'b0; err_e = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ex("reset", 3'd0, 2'd0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0);
        rst = 1'b0;

        run_instr(4'd0, 1'b0, 0, 0);   // RTYPE
        run_instr(4'd1, 1'b0, 0, 0);   // ADDI
        run_instr(4'd5, 1'b0, 0, 0);   // JAL
        run_instr(4'd2, 1'b0, 1, 3);   // LW, 3 wait cycles in MEM
        run_instr(4'd4, 1'b0, 0, 0);   // BEQ not taken
        run_instr(4'd4, 1'b1, 0, 0);   // BEQ taken
        run_instr(4'd6, 1'b0, 2, 0);   // J with fetch waits
        run_instr(4'd3, 1'b0, 0, 2);   // SW
        run_instr(4'd2, 1'b0, 0, WAIT_MAX);  // ready on the watchdog limit cycle
        run_instr(4'd3, 1'b0, 0, 0);

        run_instr(4'd7, 1'b0, 0, 0);   // illegal
        run_instr(4'd0, 1'b0, 0, 0);   // flag stays sticky

        run_instr(4'd3, 1'b0, 0, WAIT_MAX + 1);  // SW timeout
        reset_pulse(3'd5);

        for (int k = 0; k < 20; k++) begin
            run_instr(4'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        do_fetch(0);                    // reset during LW MEM
        do_decode(4'd2);
        do_exec(4'd2, 1'b0);
        reset_pulse(3'd3);
        run_instr(4'd0, 1'b0, 0, 0);

        run_instr(4'd15, 1'b0, 0, 0);  // HALT opcode
        reset_pulse(3'd5);
        run_instr(4'd1, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
